slow_fast_capture_fifo: RTL and testbench
=========================================

Name: slow_fast_capture_fifo

Overview:
- Multi-channel successor to the two-clock slow-to-fast synchronizer; runs entirely in the fast (consumer) clock domain.
- The slow source drives a bundle of CHANNELS samples plus a toggle flag. The block synchronizes the toggle, captures the sample bundle on each toggle event and optionally decimates.
- Captured words are buffered in a DEPTH-entry FIFO with a valid/ready read port. Sits between the ADC sampling front end and the VGA waveform renderer.

Parameters:
N, 12, bits per channel sample
CHANNELS, 2, number of channels captured per event
SYNC_STAGES, 2, flops in the toggle synchronizer (min 2)
DEPTH, 16, FIFO entries (power of 2, min 2)
DECIM_W, 8, width of decimation ratio input

Ports:
clk  in  1  fast clock
rst_n  in  1  asynchronous active-low reset
src_data  in  CHANNELS*N  slow-domain samples, channel 0 in LSBs (asynchronous)
src_toggle  in  1  slow-domain flag, inverted once per new sample (asynchronous)
decim  in  DECIM_W  keep 1 of every decim events; 0 and 1 both mean keep all
out_data  out  CHANNELS*N  FIFO head word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head this cycle
fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: event dropped because FIFO was full
clear_overflow  in  1  synchronous clear of overflow
drop_count  out  16  events dropped; saturates at 16'hFFFF; cleared by clear_overflow

Behaviour:
Interface: one clock, clk. Reset rst_n is asynchronous, active-low. On assertion, every flop clears: outputs 0, FIFO empty, counters 0, priming state active.

Source contract: src_data is stable from SYNC_STAGES+3 clk cycles before each src_toggle transition until SYNC_STAGES+3 cycles after it. src_data is never sampled outside the capture cycle.

Toggle synchronizer:
- src_toggle passes through SYNC_STAGES flops, then one history flop.
- An event is raised combinationally when the last sync flop differs from the history flop.

Priming:
- For the first SYNC_STAGES+1 cycles after reset release, the history flop tracks the sync output and no events are generated.
- Consequence: src_toggle=1 at reset release causes no spurious capture.

Decimation:
- A counter advances on each event and wraps at max(decim,1)-1.
- An event is kept only when the counter equals 0 at that event.
- decim is sampled only when the counter is 0, so changing decim mid-window takes effect at the next wrap.

Capture:
- Edge S+1 (S = SYNC_STAGES): on a kept event, the capture register loads src_data and cap_valid is set for one cycle.
- Edge S+2: cap_valid pushes the capture register into the FIFO.
- Latency is S+2 clk edges from the first sampling edge of the toggle transition to out_valid (4 edges at defaults, FIFO empty).

FIFO:
- Show-ahead: out_data equals the head word whenever out_valid=1; out_data holds its value while out_valid=0.
- A pop occurs when out_valid && out_ready.
- A push when not full is always accepted.
- A push when full is accepted if a pop occurs in the same cycle; occupancy stays DEPTH.
- A push when full with no pop drops the word: overflow goes to 1 and drop_count increments (saturating). FIFO contents are unchanged.
- Push and pop in the same cycle on an empty FIFO: the pop does not occur (out_valid=0); the push lands and out_valid=1 on the next cycle.
- Pointers wrap modulo DEPTH.
- fill_level updates on the edge after a push/pop: +1 for a push only, -1 for a pop only, unchanged for both.

clear_overflow:
- Clears overflow and drop_count on the next edge.
- If a drop coincides with the clear, the drop wins: overflow=1, drop_count=1.

Back-to-back events: the minimum spacing is 2 clk cycles (guaranteed by the source contract). Each event is captured independently; the block has no event merging.

Reset mid-operation: FIFO contents are discarded and priming restarts. The first post-reset event is the first toggle transition seen after priming completes.

Test Plan:
- Reset release with src_toggle=1, src_data=24'hABC123, no further toggles, 50 cycles -> out_valid stays 0, fill_level=0.
- Priming done, decim=1, single toggle with src_data={12'h456,12'h123} -> out_valid rises 4 edges after the sampling edge; out_data=24'h456123; pop with out_ready=1 -> fill_level 1->0.
- decim=3, 9 toggles with src_data values 1..9 in channel 0, out_ready=1 -> exactly 3 words out, values 1, 4, 7 in order.
- out_ready=0, 20 toggles, DEPTH=16 -> fill_level=16, overflow=1, drop_count=4. Drain -> words 1..16 in order. clear_overflow pulse -> overflow=0, drop_count=0.
- FIFO full, push coinciding with pop -> push accepted, fill_level stays 16, overflow remains 0.
- rst_n asserted mid-stream with fill_level=7 -> all outputs 0 immediately. After release and priming, the next toggle yields a single word with correct data.

Source files
------------

// File: rtl/slow_fast_capture_fifo.sv
// rtl/slow_fast_capture_fifo.sv - toggle-synchronized multi-channel capture with decimation and show-ahead FIFO
// Runs entirely in the fast clock domain; src_data is only sampled in the cycle after a kept toggle event.
module slow_fast_capture_fifo #(
   parameter int N           = 12,
   parameter int CHANNELS    = 2,
   parameter int SYNC_STAGES = 2,
   parameter int DEPTH       = 16,
   parameter int DECIM_W     = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [CHANNELS*N-1:0]       src_data,
   input  logic                        src_toggle,
   input  logic [DECIM_W-1:0]          decim,
   output logic [CHANNELS*N-1:0]       out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [$clog2(DEPTH):0]      fill_level,
   output logic                        overflow,
   input  logic                        clear_overflow,
   output logic [15:0]                 drop_count
);

   localparam int W  = CHANNELS * N;
   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(SYNC_STAGES + 2);
   localparam logic [PW-1:0]      PRIME_DONE = PW'(SYNC_STAGES + 1);
   localparam logic [AW:0]        FULL_CNT   = (AW + 1)'(DEPTH);
   localparam logic [DECIM_W-1:0] DEC_ONE    = DECIM_W'(1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic [PW-1:0]          prime_cnt_q, prime_cnt_d;
   logic [DECIM_W-1:0]     dec_cnt_q, dec_cnt_d;
   logic [DECIM_W-1:0]     dec_lim_q, dec_lim_d;
   logic [W-1:0]           cap_q, cap_d;
   logic                   cap_valid_q, cap_valid_d;
   logic [W-1:0]           mem_q [DEPTH];
   logic [W-1:0]           mem_d [DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [AW:0]            count_q, count_d;
   logic [W-1:0]           out_data_q, out_data_d;
   logic                   overflow_q, overflow_d;
   logic [15:0]            drop_count_q, drop_count_d;

   logic                   priming, evt, keep;
   logic [DECIM_W-1:0]     dec_lim_new;
   logic                   full, pop, accept, drop;
   logic [AW-1:0]          rd_next;

   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], src_toggle};
      hist_d      = sync_q[SYNC_STAGES-1];
      priming     = (prime_cnt_q != PRIME_DONE);
      prime_cnt_d = priming ? prime_cnt_q + PW'(1) : prime_cnt_q;
      evt         = !priming && (sync_q[SYNC_STAGES-1] != hist_q);

      // decim is only looked at when the window restarts, so mid-window changes wait for the wrap
      dec_lim_new = (decim == '0) ? '0 : decim - DEC_ONE;
      keep        = evt && (dec_cnt_q == '0);
      dec_cnt_d   = dec_cnt_q;
      dec_lim_d   = dec_lim_q;
      if (evt) begin
         if (dec_cnt_q == '0) begin
            dec_lim_d = dec_lim_new;
            dec_cnt_d = (dec_lim_new == '0) ? '0 : DEC_ONE;
         end else begin
            dec_cnt_d = (dec_cnt_q == dec_lim_q) ? '0 : dec_cnt_q + DEC_ONE;
         end
      end

      cap_d       = keep ? src_data : cap_q;
      cap_valid_d = keep;
   end

   always_comb begin
      full     = (count_q == FULL_CNT);
      pop      = (count_q != '0) && out_ready;
      accept   = cap_valid_q && (!full || pop);
      drop     = cap_valid_q && full && !pop;
      rd_next  = rd_ptr_q + AW'(1);

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      if (accept) begin
         mem_d[wr_ptr_q] = cap_q;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      rd_ptr_d = pop ? rd_next : rd_ptr_q;

      case ({accept, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase

      // registered head keeps out_data stable while the FIFO is empty
      out_data_d = out_data_q;
      if (pop) begin
         if (count_q > (AW + 1)'(1)) out_data_d = mem_q[rd_next];
         else if (accept)            out_data_d = cap_q;
      end else if (accept && (count_q == '0)) begin
         out_data_d = cap_q;
      end

      overflow_d   = drop ? 1'b1 : (clear_overflow ? 1'b0 : overflow_q);
      drop_count_d = drop_count_q;
      if (clear_overflow)              drop_count_d = drop ? 16'd1 : 16'd0;
      else if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q       <= '0;
         hist_q       <= 1'b0;
         prime_cnt_q  <= '0;
         dec_cnt_q    <= '0;
         dec_lim_q    <= '0;
         cap_q        <= '0;
         cap_valid_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         out_data_q   <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         sync_q       <= sync_d;
         hist_q       <= hist_d;
         prime_cnt_q  <= prime_cnt_d;
         dec_cnt_q    <= dec_cnt_d;
         dec_lim_q    <= dec_lim_d;
         cap_q        <= cap_d;
         cap_valid_q  <= cap_valid_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         out_data_q   <= out_data_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = (count_q != '0);
   assign fill_level = count_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_slow_fast_capture_fifo.sv
// tb/tb_slow_fast_capture_fifo.sv - self-checking bench for slow_fast_capture_fifo
// Table-driven decimation vectors, hand sequences for FIFO corners, randomized run against a queue model.
module tb_slow_fast_capture_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] src_data;
   logic        src_toggle;
   logic [7:0]  decim;
   logic [23:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  fill_level;
   logic        overflow;
   logic        clear_overflow;
   logic [15:0] drop_count;

   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   bit          force_ready = 1'b0;
   int          ev_idx = 0;
   logic [23:0] model_q[$];

   typedef struct {
      int decim;
      int n_ev;
      int exp_words;
      int stride;
   } vec_t;
   vec_t vecs[6];

   slow_fast_capture_fifo dut (
      .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_toggle(src_toggle),
      .decim(decim), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .fill_level(fill_level), .overflow(overflow), .clear_overflow(clear_overflow),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      if (mon_en) begin
         out_ready = force_ready ? 1'b1 : ($urandom_range(0, 1) == 1);
         if (out_valid && out_ready) begin
            if (model_q.size() == 0) chk("rand_spurious_word", 32'(out_valid), 32'd0);
            else                     chk("rand_pop_data", 32'(out_data), 32'(model_q.pop_front()));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [23:0] d, input int post);
      int eff;
      src_data = d;
      repeat (5) tick();
      src_toggle = ~src_toggle;
      eff = (decim == 0) ? 1 : int'(decim);
      if (mon_en && (ev_idx % eff == 0)) model_q.push_back(d);
      ev_idx++;
      repeat (post) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      out_ready = 1'b0;
      clear_overflow = 1'b0;
      #1;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (6) tick();
      ev_idx = 0;
      model_q.delete();
   endtask

   task automatic drain_expect(input string name, input int n, input int first, input int stride);
      for (int j = 0; j < n; j++) begin
         chk({name, "_valid"}, 32'(out_valid), 32'd1);
         chk({name, "_data"}, 32'(out_data), 32'(first + j * stride));
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
      chk({name, "_empty"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int bad;
      vecs[0] = '{0, 5, 5, 1};
      vecs[1] = '{1, 5, 5, 1};
      vecs[2] = '{2, 7, 4, 2};
      vecs[3] = '{3, 9, 3, 3};
      vecs[4] = '{4, 6, 2, 4};
      vecs[5] = '{5, 3, 1, 5};

      rst_n = 1'b0;
      src_toggle = 1'b1;
      src_data = 24'hABC123;
      decim = 8'd1;
      out_ready = 1'b0;
      clear_overflow = 1'b0;
      #12;
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_data", 32'(out_data), 32'd0);
      chk("reset_fill", 32'(fill_level), 32'd0);
      chk("reset_ovf", 32'(overflow), 32'd0);
      chk("reset_drops", 32'(drop_count), 32'd0);

      // toggle already high at release must not produce a capture
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (out_valid || fill_level != 0) bad++;
      end
      chk("prime_no_spurious", 32'(bad), 32'd0);

      send({12'h456, 12'h123}, 0);
      repeat (3) tick();
      chk("lat_edge3_valid", 32'(out_valid), 32'd0);
      tick();
      chk("lat_edge4_valid", 32'(out_valid), 32'd1);
      chk("lat_data", 32'(out_data), 32'h456123);
      chk("lat_fill1", 32'(fill_level), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("lat_fill0", 32'(fill_level), 32'd0);
      chk("lat_valid0", 32'(out_valid), 32'd0);
      chk("lat_data_hold", 32'(out_data), 32'h456123);
      repeat (5) tick();

      for (int v = 0; v < 6; v++) begin
         do_reset();
         decim = 8'(vecs[v].decim);
         for (int k = 1; k <= vecs[v].n_ev; k++) send(24'(k), 5);
         chk($sformatf("decim%0d_fill", vecs[v].decim), 32'(fill_level), 32'(vecs[v].exp_words));
         drain_expect($sformatf("decim%0d", vecs[v].decim), vecs[v].exp_words, 1, vecs[v].stride);
      end

      do_reset();
      decim = 8'd1;
      for (int k = 1; k <= 20; k++) send(24'(k), 5);
      chk("ovf_fill", 32'(fill_level), 32'd16);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_drops", 32'(drop_count), 32'd4);
      drain_expect("ovf_drain", 16, 1, 1);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      chk("clr_flag", 32'(overflow), 32'd0);
      chk("clr_drops", 32'(drop_count), 32'd0);

      for (int k = 1; k <= 16; k++) send(24'(k), 5);
      chk("full_fill", 32'(fill_level), 32'd16);
      send(24'd17, 0);
      repeat (3) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pushpop_fill", 32'(fill_level), 32'd16);
      chk("pushpop_ovf", 32'(overflow), 32'd0);
      chk("pushpop_drops", 32'(drop_count), 32'd0);
      repeat (5) tick();
      send(24'd18, 5);
      send(24'd19, 5);
      chk("drop2_count", 32'(drop_count), 32'd2);
      send(24'd20, 0);
      repeat (3) tick();
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      chk("dropclr_flag", 32'(overflow), 32'd1);
      chk("dropclr_count", 32'(drop_count), 32'd1);
      repeat (5) tick();
      drain_expect("pushpop_drain", 16, 2, 1);

      do_reset();
      decim = 8'd1;
      for (int k = 1; k <= 7; k++) send(24'(k + 32), 5);
      chk("mid_fill7", 32'(fill_level), 32'd7);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'd0);
      chk("mid_rst_fill", 32'(fill_level), 32'd0);
      do_reset();
      chk("mid_post_prime", 32'(fill_level), 32'd0);
      send(24'h777AAA, 5);
      chk("mid_one_fill", 32'(fill_level), 32'd1);
      drain_expect("mid_word", 1, 32'h777AAA, 0);

      do_reset();
      decim = 8'($urandom_range(0, 4));
      mon_en = 1'b1;
      for (int k = 0; k < 30; k++) send(24'($urandom), 5);
      force_ready = 1'b1;
      repeat (20) tick();
      mon_en = 1'b0;
      out_ready = 1'b0;
      chk("rand_model_empty", 32'(model_q.size()), 32'd0);
      chk("rand_fill0", 32'(fill_level), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
